// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises single-word read/write
// transactions from requesters A and B onto one shared memory bus.
module mem_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic              a_rwb_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_rwb_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rwb_o,
    output logic              mem_oe_o,
    output logic [DATA_W-1:0] mem_dout_o,
    input  logic [DATA_W-1:0] mem_din_i,
    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic              owner_q;
    logic              rwb_q;
    logic              busy_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_dout_q;
    logic              mem_rwb_q;
    logic              mem_oe_q;

    logic              grant_b_d;
    logic              sel_rwb_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    // Arbitration: on a tie, the requester not served last wins.
    always_comb begin
        grant_b_d   = 1'b0;
        sel_rwb_d   = a_rwb_i;
        sel_addr_d  = a_addr_i;
        sel_wdata_d = a_wdata_i;
        if (a_req_i && b_req_i) begin
            grant_b_d = ~last_q;
        end else if (b_req_i) begin
            grant_b_d = 1'b1;
        end else begin
            grant_b_d = 1'b0;
        end
        if (grant_b_d) begin
            sel_rwb_d   = b_rwb_i;
            sel_addr_d  = b_addr_i;
            sel_wdata_d = b_wdata_i;
        end else begin
            sel_rwb_d   = a_rwb_i;
            sel_addr_d  = a_addr_i;
            sel_wdata_d = a_wdata_i;
        end
    end

    // Sequencer FSM; mem_addr/mem_dout double as the grant-time latches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            rwb_q      <= 1'b1;
            busy_q     <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= {DATA_W{1'b0}};
            b_rdata_q  <= {DATA_W{1'b0}};
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_dout_q <= {DATA_W{1'b0}};
            mem_rwb_q  <= 1'b1;
            mem_oe_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_req_i || b_req_i) begin
                        state_q    <= ACCESS;
                        owner_q    <= grant_b_d;
                        rwb_q      <= sel_rwb_d;
                        mem_addr_q <= sel_addr_d;
                        mem_dout_q <= sel_wdata_d;
                        mem_rwb_q  <= sel_rwb_d;
                        mem_oe_q   <= ~sel_rwb_d;
                        busy_q     <= 1'b1;
                    end
                end
                ACCESS: begin
                    state_q   <= ACK;
                    mem_rwb_q <= 1'b1;
                    mem_oe_q  <= 1'b0;
                    if (owner_q) begin
                        b_ack_q <= 1'b1;
                        if (rwb_q) begin
                            b_rdata_q <= mem_din_i;
                        end
                    end else begin
                        a_ack_q <= 1'b1;
                        if (rwb_q) begin
                            a_rdata_q <= mem_din_i;
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= owner_q;
                end
                default: begin
                    state_q   <= IDLE;
                    a_ack_q   <= 1'b0;
                    b_ack_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    mem_rwb_q <= 1'b1;
                    mem_oe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack_o    = a_ack_q;
    assign b_ack_o    = b_ack_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_dout_o = mem_dout_q;
    assign mem_rwb_o  = mem_rwb_q;
    assign mem_oe_o   = mem_oe_q;
    assign busy_o     = busy_q;
    assign owner_o    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 4x4 bus memory model, a scoreboard
// of expected acks, a vector table and hand-written corner-case sequences.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_rwb, b_req, b_rwb;
    logic [1:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [3:0] a_rdata, b_rdata;
    logic [1:0] mem_addr;
    logic       mem_rwb, mem_oe;
    logic [3:0] mem_dout, mem_din;
    logic       busy, owner;

    logic [3:0] mem_q [4];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         last_ack_cyc = 0;
    int         prev_ack_cyc = 0;

    typedef struct {
        logic       who;
        logic       rwb;
        logic [3:0] rdata;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic       who;
        logic       rwb;
        logic [1:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rdata;
    } vec_t;
    vec_t vt[8];

    mem_arbiter #(.ADDR_W(2), .DATA_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_rwb_i(a_rwb), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_rwb_i(b_rwb), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack), .b_rdata_o(b_rdata),
        .mem_addr_o(mem_addr), .mem_rwb_o(mem_rwb), .mem_oe_o(mem_oe),
        .mem_dout_o(mem_dout), .mem_din_i(mem_din),
        .busy_o(busy), .owner_o(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus memory: commits a write on the edge that ends a driven write cycle.
    always @(posedge clk) begin
        if (!mem_rwb && mem_oe) mem_q[mem_addr] <= mem_dout;
    end
    assign mem_din = mem_q[mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic who, input logic rwb, input logic [1:0] addr,
                         input logic [3:0] wdata, input logic [3:0] exp_rd);
        exp_t e;
        e.who = who;
        e.rwb = rwb;
        e.rdata = exp_rd;
        sbq.push_back(e);
        if (who) begin
            b_req = 1'b1; b_rwb = rwb; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_rwb = rwb; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // Waits for n acks; each is matched against the scoreboard head. A
    // requester drops req in its ACK cycle once it has nothing left queued.
    task automatic drain(input int n, input int budget);
        int   got = 0;
        logic who;
        bit   more;
        exp_t e;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (a_ack && b_ack) chk("dual_ack", 1, 0);
            if (a_ack || b_ack) begin
                who = b_ack;
                prev_ack_cyc = last_ack_cyc;
                last_ack_cyc = cyc;
                got++;
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_owner", int'(who), int'(e.who));
                    if (e.rwb) chk("rdata", int'(who ? b_rdata : a_rdata), int'(e.rdata));
                end
                more = 1'b0;
                foreach (sbq[i]) if (sbq[i].who == who) more = 1'b1;
                if (!more) begin
                    if (who) b_req = 1'b0;
                    else a_req = 1'b0;
                end
            end
        end
        chk("ack_timeout", got, n);
    endtask

    task automatic txn(input logic who, input logic rwb, input logic [1:0] addr,
                       input logic [3:0] wdata, input logic [3:0] exp_rd);
        logic [3:0] other;
        other = who ? a_rdata : b_rdata;
        drive(who, rwb, addr, wdata, exp_rd);
        drain(1, 10);
        chk("other_rdata_held", int'(who ? a_rdata : b_rdata), int'(other));
    endtask

    initial begin
        logic [3:0] held;

        vt[0] = '{1'b0, 1'b1, 2'b10, 4'b0000, 4'b1010};
        vt[1] = '{1'b1, 1'b1, 2'b11, 4'b0000, 4'b1111};
        vt[2] = '{1'b1, 1'b0, 2'b00, 4'b0011, 4'b0000};
        vt[3] = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b0011};
        vt[4] = '{1'b0, 1'b0, 2'b11, 4'b0110, 4'b0000};
        vt[5] = '{1'b1, 1'b1, 2'b11, 4'b0000, 4'b0110};
        vt[6] = '{1'b1, 1'b1, 2'b01, 4'b0000, 4'b0101};
        vt[7] = '{1'b0, 1'b1, 2'b01, 4'b0000, 4'b0101};

        a_rwb = 1'b1; a_addr = 2'b00; a_wdata = 4'b0000;
        b_rwb = 1'b1; b_addr = 2'b00; b_wdata = 4'b0000;
        do_reset();

        chk("rst_a_ack", int'(a_ack), 0);
        chk("rst_b_ack", int'(b_ack), 0);
        chk("rst_a_rdata", int'(a_rdata), 0);
        chk("rst_b_rdata", int'(b_rdata), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_rwb", int'(mem_rwb), 1);
        chk("rst_mem_oe", int'(mem_oe), 0);
        chk("rst_mem_dout", int'(mem_dout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 0);

        // A writes 0101 to 01, cycle by cycle.
        drive(1'b0, 1'b0, 2'b01, 4'b0101, 4'b0000);
        @(posedge clk); #1;
        chk("wr_access_rwb", int'(mem_rwb), 0);
        chk("wr_access_oe", int'(mem_oe), 1);
        chk("wr_access_addr", int'(mem_addr), 1);
        chk("wr_access_dout", int'(mem_dout), 5);
        chk("wr_access_busy", int'(busy), 1);
        chk("wr_access_noack", int'(a_ack), 0);
        @(posedge clk); #1;
        chk("wr_ack_a", int'(a_ack), 1);
        chk("wr_ack_rwb", int'(mem_rwb), 1);
        chk("wr_ack_oe", int'(mem_oe), 0);
        chk("wr_ack_busy", int'(busy), 1);
        drain(1, 4);
        @(posedge clk); #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_addr_held", int'(mem_addr), 1);
        @(negedge clk);
        txn(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0101);

        // Simultaneous requests after reset: A first, B three cycles later.
        do_reset();
        drive(1'b0, 1'b0, 2'b10, 4'b1010, 4'b0000);
        drive(1'b1, 1'b0, 2'b11, 4'b1111, 4'b0000);
        drain(2, 12);
        chk("tie_ack_gap", last_ack_cyc - prev_ack_cyc, 3);

        for (int i = 0; i < 8; i++)
            txn(vt[i].who, vt[i].rwb, vt[i].addr, vt[i].wdata, vt[i].exp_rdata);

        // Both held for six transactions: strict alternation A,B,A,B,A,B.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b10, 4'b0000, 4'b1010);
            drive(1'b1, 1'b1, 2'b00, 4'b0000, 4'b0011);
        end
        drain(6, 40);
        chk("alt_sb_empty", sbq.size(), 0);

        // B changes addr/wdata during its ACCESS cycle.
        @(negedge clk);
        held = b_rdata;
        drive(1'b1, 1'b0, 2'b01, 4'b1001, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        chk("latch_addr", int'(mem_addr), 1);
        chk("latch_dout", int'(mem_dout), 9);
        b_addr = 2'b10;
        b_wdata = 4'b0000;
        drain(1, 4);
        chk("latch_b_rdata", int'(b_rdata), int'(held));
        txn(1'b0, 1'b1, 2'b01, 4'b0000, 4'b1001);
        txn(1'b0, 1'b1, 2'b10, 4'b0000, 4'b1010);

        // Reset during a write ACCESS aborts the write.
        @(negedge clk);
        a_req = 1'b1; a_rwb = 1'b0; a_addr = 2'b00; a_wdata = 4'b1100;
        @(posedge clk); #2;
        chk("abort_in_access", int'(mem_rwb), 0);
        rst = 1'b1;
        #1;
        chk("abort_rwb", int'(mem_rwb), 1);
        chk("abort_oe", int'(mem_oe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ack", int'(a_ack), 0);
        a_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", int'(a_ack | b_ack), 0);
        end
        chk("abort_a_rdata", int'(a_rdata), 0);
        txn(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and access sequencer for the 4-word × 4-bit bus memory. Two requesters each issue single-word read or write transactions through a req/ack handshake. The block serialises them onto the memory's single address/rwb/data bus and returns read data per requester. It sits between the requesters and the memory, and is the only driver of the memory's address, mode and bus-enable signals.

## Interface

Parameters:
- ADDR_W, 2, memory address width
- DATA_W, 4, memory word width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  requester A transaction request; held until a_ack
- a_rwb  in  1  A mode: 1 = read, 0 = write
- a_addr  in  ADDR_W  A word address
- a_wdata  in  DATA_W  A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  DATA_W  A read data; valid while a_ack = 1, then held
- b_req, b_rwb, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B
- mem_addr  out  ADDR_W  memory address
- mem_rwb  out  1  memory mode: 1 = read/idle, 0 = write
- mem_oe  out  1  1 = drive mem_dout onto the data bus (writes only)
- mem_dout  out  DATA_W  write data toward the bus
- mem_din  in  DATA_W  data bus value, sampled for reads
- busy  out  1  1 while in ACCESS or ACK
- owner  out  1  requester being served (0 = A, 1 = B); meaningful while busy = 1

## Operation

- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester not served last, using the `last` pointer.
  - On grant: latch owner, addr, rwb and wdata into internal registers, then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr; mem_rwb = latched rwb.
  - mem_oe = ~latched rwb; mem_dout = latched wdata.
  - A write commits at the clk edge that ends ACCESS.
  - A read samples mem_din into the owner's rdata register at that same edge.
  - Next state: ACK.
- ACK (exactly one cycle):
  - Owner's ack = 1; `last` <= owner.
  - Memory signals return to idle values: mem_rwb = 1, mem_oe = 0.
  - Next state: IDLE unconditionally.
- Requester rules:
  - Deassert req in the ACK cycle or later.
  - req still high in the following IDLE cycle is treated as a new transaction.
  - req/rwb/addr/wdata changes while busy are ignored, because values are latched at grant.
  - The non-owner's req is never lost; it waits in IDLE arbitration.
- Idle values:
  - mem_rwb = 1, mem_oe = 0.
  - mem_addr and mem_dout hold their last value; no spurious write is possible.
- The rdata register of the non-owner is never modified.

## Timing

- All outputs are registered or decoded from state and registers; no combinational path from a req input to any output.
- Reset values:
  - State IDLE, `last` = 1 (so A wins the first tie).
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - mem_addr = 0, mem_rwb = 1, mem_oe = 0, mem_dout = 0.
  - busy = 0, owner = 0.
- Latency: req sampled high at edge N → ACCESS during cycle N..N+1 → ack high during cycle N+1..N+2.
- Throughput: one transaction per 3 cycles with back-to-back requests.
- Alternation: with both req held continuously, grants alternate A, B, A, B.
- Reset asserted mid-ACCESS:
  - Outputs go to reset values immediately (asynchronous).
  - mem_rwb is forced to 1 at once, so a write not yet clocked is aborted.
  - No ack is issued; the requester must re-request.
- Reset asserted during ACK: the ack pulse is truncated; the operation already completed.
- Simultaneous events: a req arriving for one requester during the other's ACK cycle is served at the next IDLE edge.

## Test plan

- Reset then A writes 4'b0101 to address 01; A later reads address 01. Required: one-cycle mem_oe/mem_rwb = 0 at mem_addr = 01; a_ack two cycles after each req; a_rdata = 0101 on the read ack.
- A and B both request in the same cycle (A writes 1010 to 10, B writes 1111 to 11). Required: A is served first, B next; both acks come from distinct transactions 3 cycles apart; read-back returns 1010 and 1111.
- Both req held high for 6 transactions. Required: owner sequence A, B, A, B, A, B; no two consecutive grants to the same requester.
- B changes addr and wdata during its ACCESS cycle. Required: memory sees the values latched at grant; b_rdata is unaffected by the changes.
- rst asserted during a write ACCESS to address 00 holding 0011, writing 1100. Required: mem_rwb = 1 immediately; no ack; address 00 still reads 0011 after reset.
- Read from B while A is idle. Required: a_rdata keeps its old value; only b_ack pulses.
